// File: rtl/pulse_pacer.sv
// pulse_pacer
//   Sits in the source clock domain, directly upstream of a pulse
//   synchronizer. Event requests can arrive on any cycle and are held in a
//   saturating pending counter. They are re-emitted as single-cycle pulses
//   with at least MIN_GAP idle cycles after each one, so the synchronizer
//   never sees two pulses close enough to merge or lose one.
//
// Parameters
//   MIN_GAP   idle cycles forced after every pulse (>=1)
//   CNT_W     pending counter width; capacity 2**CNT_W-1
// Ports
//   clk_src    in   source domain clock
//   rst_n      in   asynchronous active-low reset
//   ev_in      in   event request, one event per high cycle
//   ovf_clr    in   single-cycle clear for the overflow flag
//   pulse_out  out  registered pulse, drives the synchronizer input
//   pending    out  events queued and not yet emitted
//   busy       out  FSM not idle or events still queued
//   overflow   out  sticky, set when an event had to be dropped
module pulse_pacer #(
  parameter int MIN_GAP = 3,
  parameter int CNT_W   = 4
) (
  input  logic             clk_src,
  input  logic             rst_n,
  input  logic             ev_in,
  input  logic             ovf_clr,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  if (MIN_GAP < 1 || CNT_W < 1) begin : g_bad_param
    $error("pulse_pacer: MIN_GAP and CNT_W must both be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;

  logic issue_win;  // cycle in which a new pulse may be launched
  logic issue;
  logic dec;        // a pulse is launched this cycle
  logic inc;
  logic drop;

  always_comb begin
    issue_win = (state_q == IDLE) || ((state_q == GAP) && (gap_q == '0));
    issue     = (pending_q != '0) || ev_in;
    dec       = issue_win && issue;
    // Full queue only rejects the event when nothing leaves this cycle.
    drop      = ev_in && (pending_q == PEND_MAX) && !dec;
    inc       = ev_in && !drop;
  end

  // State register
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dec) state_d = PULSE;
      PULSE:   state_d = GAP;
      GAP:     if (gap_q == '0) state_d = dec ? PULSE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath next values
  always_comb begin
    gap_d = gap_q;
    if (state_q == PULSE)                      gap_d = GAP_LOAD;
    else if (state_q == GAP && gap_q != '0)    gap_d = gap_q - 1'b1;

    // inc and dec together cancel; drop guarantees no wrap at the top and
    // dec requires pending!=0 or ev_in, so no wrap at the bottom either.
    pending_d = pending_q + CNT_W'(inc) - CNT_W'(dec);

    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;

    pulse_d = (state_d == PULSE);
    busy_d  = (state_d != IDLE) || (pending_d != '0);
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      gap_q     <= '0;
      pending_q <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      gap_q     <= gap_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pulse_out = pulse_q;
  assign pending   = pending_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_pacer.sv
// Bench for pulse_pacer. Three instances share one stimulus stream:
//   A: MIN_GAP=3, CNT_W=4   B: MIN_GAP=3, CNT_W=2   C: MIN_GAP=6, CNT_W=4
// C feeds a behavioural toggle synchronizer clocked at 3x the source period.
module tb_pulse_pacer;

  logic clk_src = 1'b0;
  logic clk_dst = 1'b0;
  logic rst_n, ev_in, ovf_clr;

  logic       a_pulse, a_busy, a_ovf;
  logic [3:0] a_pend;
  logic       b_pulse, b_busy, b_ovf;
  logic [1:0] b_pend;
  logic       c_pulse, c_busy, c_ovf;
  logic [3:0] c_pend;

  always #5  clk_src = ~clk_src;
  always #15 clk_dst = ~clk_dst;

  pulse_pacer #(.MIN_GAP(3), .CNT_W(4)) u_a (
    .clk_src(clk_src), .rst_n(rst_n), .ev_in(ev_in), .ovf_clr(ovf_clr),
    .pulse_out(a_pulse), .pending(a_pend), .busy(a_busy), .overflow(a_ovf));
  pulse_pacer #(.MIN_GAP(3), .CNT_W(2)) u_b (
    .clk_src(clk_src), .rst_n(rst_n), .ev_in(ev_in), .ovf_clr(ovf_clr),
    .pulse_out(b_pulse), .pending(b_pend), .busy(b_busy), .overflow(b_ovf));
  pulse_pacer #(.MIN_GAP(6), .CNT_W(4)) u_c (
    .clk_src(clk_src), .rst_n(rst_n), .ev_in(ev_in), .ovf_clr(ovf_clr),
    .pulse_out(c_pulse), .pending(c_pend), .busy(c_busy), .overflow(c_ovf));

  // Toggle-style pulse synchronizer downstream of C
  logic tog = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   d_cnt = 0;
  always @(posedge clk_src) tog <= tog ^ c_pulse;
  always @(posedge clk_dst) begin
    s1 <= tog; s2 <= s1; s3 <= s2;
    d_cnt <= d_cnt + ((s2 ^ s3) ? 1 : 0);
  end

  int n_tests = 0, n_fail = 0;
  int np_a = 0, np_b = 0, np_c = 0;

  // Reference model: a pulse may launch once MIN_GAP cycles have passed
  // since the previous pulse cycle; queue depth is a plain integer.
  typedef struct {
    int pend; int last; int cyc; bit ovf; int pulses; int drops; int evs;
  } mdl_t;
  mdl_t ma, mb, mc;

  function automatic void mreset(output mdl_t m);
    m = '{pend:0, last:-100, cyc:0, ovf:1'b0, pulses:0, drops:0, evs:0};
  endfunction

  function automatic void mstep(inout mdl_t m, input int mg, input int pmax,
                                input bit ev, input bit clr);
    bit issue, drop;
    issue = (m.cyc >= m.last + mg) && (m.pend != 0 || ev);
    drop  = ev && (m.pend == pmax) && !issue;
    if (issue) begin m.last = m.cyc + 1; m.pulses++; end
    m.pend = m.pend + ((ev && !drop) ? 1 : 0) - (issue ? 1 : 0);
    if (drop) begin m.ovf = 1'b1; m.drops++; end
    else if (clr) m.ovf = 1'b0;
    if (ev) m.evs++;
    m.cyc++;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input int mg, input bit p,
                     input int pend, input bit busy, input bit ovf);
    chk({tag, ".pulse"},    p,    (m.cyc == m.last) ? 1 : 0);
    chk({tag, ".pending"},  pend, m.pend);
    chk({tag, ".busy"},     busy, ((m.cyc <= m.last + mg) || m.pend != 0) ? 1 : 0);
    chk({tag, ".overflow"}, ovf,  m.ovf);
  endtask

  // Drive one cycle of inputs, advance the models, check all instances.
  task automatic cyc(input bit ev, input bit clr);
    ev_in = ev; ovf_clr = clr;
    mstep(ma, 3, 15, ev, clr);
    mstep(mb, 3, 3,  ev, clr);
    mstep(mc, 6, 15, ev, clr);
    @(posedge clk_src); #1;
    if (a_pulse) np_a++;
    if (b_pulse) np_b++;
    if (c_pulse) np_c++;
    cmp("A", ma, 3, a_pulse, int'(a_pend), a_busy, a_ovf);
    cmp("B", mb, 3, b_pulse, int'(b_pend), b_busy, b_ovf);
    cmp("C", mc, 6, c_pulse, int'(c_pend), c_busy, c_ovf);
  endtask

  // Directed vectors for A: inputs in cycle i, outputs seen in cycle i+1
  typedef struct { bit ev; bit clr; bit p; int pend; bit busy; bit ovf; } vec_t;
  vec_t tbl[$];
  function automatic void add(bit ev, bit p, int pend, bit busy);
    vec_t v;
    v = '{ev:ev, clr:1'b0, p:p, pend:pend, busy:busy, ovf:1'b0};
    tbl.push_back(v);
  endfunction

  initial begin
    int snap, snap_d, snap_p, ev0, dr0, pend0;
    bit found;
    // Burst of 5: pulses every 4 cycles, pending peaks at 3
    add(1,1,0,1); add(1,0,1,1); add(1,0,2,1); add(1,0,3,1); add(1,1,3,1);
    add(0,0,3,1); add(0,0,3,1); add(0,0,3,1); add(0,1,2,1);
    add(0,0,2,1); add(0,0,2,1); add(0,0,2,1); add(0,1,1,1);
    add(0,0,1,1); add(0,0,1,1); add(0,0,1,1); add(0,1,0,1);
    add(0,0,0,1); add(0,0,0,1); add(0,0,0,1); add(0,0,0,0);
    // Single event from idle: one pulse, busy for 1+MIN_GAP cycles
    add(1,1,0,1); add(0,0,0,1); add(0,0,0,1); add(0,0,0,1); add(0,0,0,0);

    rst_n = 1'b0; ev_in = 1'b0; ovf_clr = 1'b0;
    #22;
    chk("reset.pulse", a_pulse, 0);
    chk("reset.pending", int'(a_pend), 0);
    chk("reset.busy", a_busy, 0);
    chk("reset.overflow", a_ovf, 0);
    mreset(ma); mreset(mb); mreset(mc);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].ev, tbl[i].clr);
      chk($sformatf("vec%0d.pulse", i), a_pulse, tbl[i].p);
      chk($sformatf("vec%0d.pending", i), int'(a_pend), tbl[i].pend);
      chk($sformatf("vec%0d.busy", i), a_busy, tbl[i].busy);
      chk($sformatf("vec%0d.overflow", i), a_ovf, tbl[i].ovf);
    end

    // Overflow on B: 8 back-to-back events, last 3 dropped
    snap = np_b;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0);
      if (i == 4) chk("ovf.before_drop", b_ovf, 0);
      if (i == 5) chk("ovf.after_drop", b_ovf, 1);
    end
    repeat (22) cyc(0, 0);
    chk("ovf.pulse_count", np_b - snap, 5);
    cyc(0, 1);
    chk("ovf.cleared", b_ovf, 0);

    // Clear collides with a drop: set wins
    for (int i = 0; i < 8; i++) begin
      cyc(1, i == 6);
      if (i == 6) chk("collide.overflow", b_ovf, 1);
    end
    repeat (40) cyc(0, 0);

    // Reset asserted mid-pulse
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1, 0);
      if (a_pulse) found = 1'b1;
    end
    chk("rst.found_pulse", found, 1);
    #2 rst_n = 1'b0; ev_in = 1'b0;
    #1;
    chk("rst.pulse_async", a_pulse, 0);
    chk("rst.pending", int'(a_pend), 0);
    chk("rst.busy", a_busy, 0);
    chk("rst.overflow", b_ovf, 0);
    @(posedge clk_src); @(posedge clk_src); #2;
    mreset(ma); mreset(mb); mreset(mc);
    rst_n = 1'b1;
    snap = np_a;
    repeat (6) cyc(0, 0);
    chk("rst.no_spurious", np_a - snap, 0);

    // Random traffic; C through the synchronizer
    repeat (10) @(posedge clk_dst);
    @(posedge clk_src); #1;
    snap_d = d_cnt; snap_p = np_c; ev0 = mc.evs; dr0 = mc.drops; pend0 = int'(c_pend);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3);
    repeat (150) cyc(0, 0);
    repeat (6) @(posedge clk_dst);
    #1;
    chk("sync.d_out_count", d_cnt - snap_d, np_c - snap_p);
    chk("sync.conservation", (np_c - snap_p) + int'(c_pend) - pend0 + (mc.drops - dr0),
        mc.evs - ev0);
    chk("sync.drained", int'(c_pend), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
